// File: rtl/fetch_decode_buffer_pkg.sv
// Shared fetch-side types: the buffered packet layout and default buffer depth.
package fetch_pkg;

    localparam int FETCH_SIZE      = 32;
    localparam int FETCH_BUF_DEPTH = 4;

    typedef struct packed {
        logic [FETCH_SIZE-1:0] instruction;
        logic [FETCH_SIZE-1:0] current_pc;
        logic [FETCH_SIZE-1:0] imm;
        logic [FETCH_SIZE-1:0] pc_save;
        logic                  branch_prediction;
    } fetch_packet_t;

endpackage

// File: rtl/fetch_decode_buffer_if.sv
// Fetch->decode handshake bundle; master is the fetch/decode environment, slave is the buffer.
interface fetch_decode_buffer_if #(
    parameter int size  = 32,
    parameter int DEPTH = 4
);
    logic                     valid_i;
    logic [size-1:0]          instruction_i;
    logic [size-1:0]          current_pc_i;
    logic [size-1:0]          imm_i;
    logic [size-1:0]          pc_save_i;
    logic                     branch_prediction_i;
    logic                     flush;
    logic                     ready_i;
    logic                     ready_o;
    logic                     buble_o;
    logic                     valid_o;
    logic [size-1:0]          instruction_o;
    logic [size-1:0]          current_pc_o;
    logic [size-1:0]          imm_o;
    logic [size-1:0]          pc_save_o;
    logic                     branch_prediction_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        output valid_i, instruction_i, current_pc_i, imm_i, pc_save_i,
               branch_prediction_i, flush, ready_i,
        input  ready_o, buble_o, valid_o, instruction_o, current_pc_o, imm_o,
               pc_save_o, branch_prediction_o, count_o
    );

    modport slave (
        input  valid_i, instruction_i, current_pc_i, imm_i, pc_save_i,
               branch_prediction_i, flush, ready_i,
        output ready_o, buble_o, valid_o, instruction_o, current_pc_o, imm_o,
               pc_save_o, branch_prediction_o, count_o
    );

endinterface

// File: rtl/fetch_decode_buffer_ctrl.sv
// Pointer/occupancy control for the fetch buffer; handles flush and, with
// FETCH_BUF_BYPASS_EN defined, the empty-buffer bypass decision.
module fetch_buffer_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          valid_i,
    input  logic          ready_i,
`ifdef FETCH_BUF_BYPASS_EN
    output logic          bypass_o,
`endif
    output logic [AW-1:0] wptr_o,
    output logic [AW-1:0] rptr_o,
    output logic [CW-1:0] count_o,
    output logic          push_o,
    output logic          ready_o,
    output logic          valid_o
);

    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          stored_vld;
    logic          push;
    logic          pop;

    assign stored_vld = (count_q != '0);
    assign ready_o    = (count_q < CW'(DEPTH));
    assign pop        = stored_vld && ready_i && !flush_i;

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;
    // A bypassed packet taken by decode in the same cycle never enters storage.
    assign bypass   = !stored_vld && valid_i && !flush_i && !reset;
    assign push     = valid_i && ready_o && !flush_i && !(bypass && ready_i);
    assign valid_o  = stored_vld || bypass;
    assign bypass_o = bypass;
`else
    assign push     = valid_i && ready_o && !flush_i;
    assign valid_o  = stored_vld;
`endif

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + AW'(1);
            if (pop)  rptr_d = rptr_q + AW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign wptr_o  = wptr_q;
    assign rptr_o  = rptr_q;
    assign count_o = count_q;
    assign push_o  = push;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Fetch-to-decode packet FIFO: packet storage and head-field muxing.
// Optional same-cycle empty bypass is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_decode_buffer
    import fetch_pkg::*;
#(
    parameter int size  = FETCH_SIZE,
    parameter int DEPTH = FETCH_BUF_DEPTH
) (
    input logic                  clk,
    input logic                  reset,
    fetch_decode_buffer_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;
    logic          push;
    fetch_packet_t in_pkt;
    fetch_packet_t head;
    fetch_packet_t slots [DEPTH];

    always_comb begin
        in_pkt                   = '0;
        in_pkt.instruction       = FETCH_SIZE'(bus.instruction_i);
        in_pkt.current_pc        = FETCH_SIZE'(bus.current_pc_i);
        in_pkt.imm               = FETCH_SIZE'(bus.imm_i);
        in_pkt.pc_save           = FETCH_SIZE'(bus.pc_save_i);
        in_pkt.branch_prediction = bus.branch_prediction_i;
    end

`ifdef FETCH_BUF_BYPASS_EN
    logic bypass;
`endif

    fetch_buffer_ctrl #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_ctrl (
        .clk      (clk),
        .reset    (reset),
        .flush_i  (bus.flush),
        .valid_i  (bus.valid_i),
        .ready_i  (bus.ready_i),
`ifdef FETCH_BUF_BYPASS_EN
        .bypass_o (bypass),
`endif
        .wptr_o   (wptr),
        .rptr_o   (rptr),
        .count_o  (count),
        .push_o   (push),
        .ready_o  (bus.ready_o),
        .valid_o  (bus.valid_o)
    );

    // Slot 0 is the head after reset, so only it is cleared; the rest stay unreset.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        fetch_packet_t slot_q;
        if (i == 0) begin : g_rst
            always_ff @(posedge clk or posedge reset) begin
                if (reset)                          slot_q <= '0;
                else if (push && wptr == AW'(i))    slot_q <= in_pkt;
            end
        end else begin : g_nrst
            always_ff @(posedge clk) begin
                if (push && wptr == AW'(i)) slot_q <= in_pkt;
            end
        end
        assign slots[i] = slot_q;
    end

    always_comb begin
        head = slots[rptr];
`ifdef FETCH_BUF_BYPASS_EN
        if (bypass) head = in_pkt;
`endif
    end

    assign bus.instruction_o       = size'(head.instruction);
    assign bus.current_pc_o        = size'(head.current_pc);
    assign bus.imm_o               = size'(head.imm);
    assign bus.pc_save_o           = size'(head.pc_save);
    assign bus.branch_prediction_o = head.branch_prediction;
    assign bus.buble_o             = !bus.ready_o;
    assign bus.count_o             = count;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Self-checking bench for fetch_decode_buffer (default build, no bypass).
module tb_fetch_decode_buffer;
    import fetch_pkg::*;

    localparam int SZ    = 32;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    fetch_packet_t q[$];

    fetch_decode_buffer_if #(.size(SZ), .DEPTH(DEPTH)) bus ();

    fetch_decode_buffer #(.size(SZ), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        bus.valid_i             = v;
        bus.current_pc_i        = pc;
        bus.instruction_i       = $urandom;
        bus.imm_i               = $urandom;
        bus.pc_save_i           = $urandom;
        bus.branch_prediction_i = 1'($urandom_range(0, 1));
        bus.ready_i             = rdy;
        bus.flush               = fl;
    endtask

    // Compare DUT against the queue model, then advance one clock.
    task automatic cycle();
        fetch_packet_t pkt;
        int  n;
        bit  do_push, do_pop;
        n = q.size();
        chk("count", 32'(bus.count_o), 32'(n));
        chk("valid", 32'(bus.valid_o), 32'(n > 0));
        chk("ready", 32'(bus.ready_o), 32'(n < DEPTH));
        chk("buble", 32'(bus.buble_o), 32'(n >= DEPTH));
        if (n > 0) begin
            chk("head_pc",   bus.current_pc_o,  q[0].current_pc);
            chk("head_inst", bus.instruction_o, q[0].instruction);
            chk("head_imm",  bus.imm_o,         q[0].imm);
            chk("head_save", bus.pc_save_o,     q[0].pc_save);
            chk("head_bp",   32'(bus.branch_prediction_o), 32'(q[0].branch_prediction));
        end
        pkt = '{bus.instruction_i, bus.current_pc_i, bus.imm_i, bus.pc_save_i,
                bus.branch_prediction_i};
        do_push = bus.valid_i && (n < DEPTH) && !bus.flush;
        do_pop  = (n > 0) && bus.ready_i && !bus.flush;
        @(posedge clk);
        if (bus.flush) q.delete();
        else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(pkt);
        end
        #1;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_ready", 32'(bus.ready_o), 32'd1);
        chk("rst_buble", 32'(bus.buble_o), 32'd0);
        chk("rst_pc",    bus.current_pc_o, 32'd0);
        chk("rst_inst",  bus.instruction_o, 32'd0);
        reset = 1'b0;
        q.delete();

        // Fill to full with ready_i low; the fifth packet must be dropped.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'(k * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h10, 1'b0, 1'b0);
        cycle();
        chk("full_count", 32'(bus.count_o), 32'd4);
        chk("full_ready", 32'(bus.ready_o), 32'd0);
        chk("full_buble", 32'(bus.buble_o), 32'd1);

        // Drain in order.
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("drain_pc", bus.current_pc_o, 32'(k * 4));
            cycle();
        end
        chk("drained_valid", 32'(bus.valid_o), 32'd0);
        chk("drained_count", 32'(bus.count_o), 32'd0);

        // Steady push/pop at occupancy 2 across pointer wrap.
        drive(1'b1, 32'h100, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h104, 1'b0, 1'b0); cycle();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'(32'h108 + k * 4), 1'b1, 1'b0);
            cycle();
            chk("stream_count", 32'(bus.count_o), 32'd2);
        end
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        cycle(); cycle();

        // Flush at count 3 drops the concurrent packet.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'(32'h200 + k * 4), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 32'h40, 1'b0, 1'b1);
        cycle();
        chk("flush_count", 32'(bus.count_o), 32'd0);
        chk("flush_valid", 32'(bus.valid_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h44, 1'b1, 1'b1);
            cycle();
            chk("flush_hold_ready", 32'(bus.ready_o), 32'd1);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        chk("post_flush_valid", 32'(bus.valid_o), 32'd0);

        // Asynchronous reset between edges at count 2.
        drive(1'b1, 32'h300, 1'b0, 1'b0); cycle();
        drive(1'b1, 32'h304, 1'b0, 1'b0); cycle();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        chk("pre_arst_count", 32'(bus.count_o), 32'd2);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_ready", 32'(bus.ready_o), 32'd1);
        chk("arst_pc",    bus.current_pc_o, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        cycle();

        // Randomized traffic against the queue model.
        for (int k = 0; k < 400; k++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
